// File: rtl/tc_pkg.sv
// Shared types and default timing for the test clock sequencer.
// The defaults assume external ICG/mux cells that settle within a few sequencer cycles.
package tc_pkg;

  typedef enum logic [2:0] {
    FUNC,
    GATE,
    SWAP,
    SETTLE,
    TEST
  } tc_state_t;

  localparam int TC_N_CH      = 6;
  localparam int TC_GATE_DLY  = 4;
  localparam int TC_SETTLE_DLY = 8;
  localparam int TC_CNT_W     = 8;

endpackage

// File: rtl/tc_dly_cnt.sv
// Loadable down-counter with zero flag; load wins over enable and the count stops at zero.
// Latency: a load is visible on the zero flag in the following cycle.
module tc_dly_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/test_clk_seq.sv
// Sequences scan test entry/exit per clock domain: gate, switch select, settle, ungate.
// Requests arriving while busy are ignored; the request level is re-evaluated on reaching FUNC/TEST.
module test_clk_seq
  import tc_pkg::*;
#(
  parameter int N_CH       = TC_N_CH,
  parameter int GATE_DLY   = TC_GATE_DLY,
  parameter int SETTLE_DLY = TC_SETTLE_DLY,
  parameter int CNT_W      = TC_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            test_req,
  input  logic [N_CH-1:0] ch_mask,
  input  logic            scan_en_req,
  output logic [N_CH-1:0] clk_en,
  output logic [N_CH-1:0] test_sel,
  output logic            scan_en,
  output logic            test_active,
  output logic            busy
);

  localparam logic [CNT_W-1:0] L_GATE_LD   = CNT_W'(GATE_DLY - 1);
  localparam logic [CNT_W-1:0] L_SETTLE_LD = CNT_W'(SETTLE_DLY - 1);

  tc_state_t        r_state;
  logic [N_CH-1:0]  r_mask_q;
  logic             r_dir;
  logic [N_CH-1:0]  r_clk_en;
  logic [N_CH-1:0]  r_test_sel;
  logic             r_scan_en;
  logic             r_test_active;
  logic             r_busy;

  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_load_val;
  logic             w_cnt_en;
  logic             w_cnt_zero;

  // One counter serves both delay phases; it is reloaded on entry to each.
  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = L_GATE_LD;
    w_cnt_en       = 1'b0;
    case (r_state)
      FUNC:    w_cnt_load = test_req;
      TEST:    w_cnt_load = ~test_req;
      GATE:    w_cnt_en   = ~w_cnt_zero;
      SWAP: begin
        w_cnt_load     = 1'b1;
        w_cnt_load_val = L_SETTLE_LD;
      end
      SETTLE:  w_cnt_en   = ~w_cnt_zero;
      default: w_cnt_load = 1'b0;
    endcase
  end

  tc_dly_cnt #(
    .CNT_W(CNT_W)
  ) u_dly_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_cnt_load),
    .i_load_val(w_cnt_load_val),
    .i_en      (w_cnt_en),
    .o_zero    (w_cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= FUNC;
      r_mask_q      <= '0;
      r_dir         <= 1'b0;
      r_clk_en      <= '1;
      r_test_sel    <= '0;
      r_scan_en     <= 1'b0;
      r_test_active <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_scan_en <= 1'b0;
      case (r_state)
        FUNC: begin
          if (test_req) begin
            r_mask_q <= ch_mask;
            r_dir    <= 1'b1;
            r_clk_en <= ~ch_mask;
            r_busy   <= 1'b1;
            r_state  <= GATE;
          end
        end
        GATE: begin
          if (w_cnt_zero) r_state <= SWAP;
        end
        SWAP: begin
          r_test_sel <= r_dir ? r_mask_q : '0;
          r_state    <= SETTLE;
        end
        SETTLE: begin
          if (w_cnt_zero) begin
            r_clk_en      <= '1;
            r_test_active <= r_dir;
            r_busy        <= 1'b0;
            r_state       <= r_dir ? TEST : FUNC;
          end
        end
        TEST: begin
          if (!test_req) begin
            r_dir         <= 1'b0;
            r_test_active <= 1'b0;
            r_clk_en      <= ~r_mask_q;
            r_busy        <= 1'b1;
            r_state       <= GATE;
          end else begin
            r_scan_en <= scan_en_req;
          end
        end
        default: r_state <= FUNC;
      endcase
    end
  end

  assign clk_en      = r_clk_en;
  assign test_sel    = r_test_sel;
  assign scan_en     = r_scan_en;
  assign test_active = r_test_active;
  assign busy        = r_busy;

endmodule

// File: tb/tb_test_clk_seq.sv
// Scoreboard bench for test_clk_seq: default timing on DUT a, minimum delays on DUT b.
// Expected outputs are queued with their due cycle when stimulus is applied.
module tb_test_clk_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_req, a_sreq, b_rst, b_req, b_sreq;
  logic [5:0] a_mask, b_mask;
  logic [5:0] a_en, a_sel, b_en, b_sel;
  logic       a_sen, a_act, a_bsy, b_sen, b_act, b_bsy;

  test_clk_seq u_dut_a (
    .clk(clk), .rst(a_rst), .test_req(a_req), .ch_mask(a_mask), .scan_en_req(a_sreq),
    .clk_en(a_en), .test_sel(a_sel), .scan_en(a_sen), .test_active(a_act), .busy(a_bsy)
  );

  test_clk_seq #(.GATE_DLY(1), .SETTLE_DLY(1)) u_dut_b (
    .clk(clk), .rst(b_rst), .test_req(b_req), .ch_mask(b_mask), .scan_en_req(b_sreq),
    .clk_en(b_en), .test_sel(b_sel), .scan_en(b_sen), .test_active(b_act), .busy(b_bsy)
  );

  typedef struct {
    int          cyc;
    bit          dut_b;
    string       tag;
    logic [14:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_err = 0;
  int   n_chk = 0;
  int   a_viol = 0;
  int   b_viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Packed as {clk_en, test_sel, scan_en, test_active, busy}.
  task automatic expect_at(input bit b, input int off, input string tag,
                           input logic [5:0] en, input logic [5:0] sel,
                           input logic sen, input logic act, input logic bsy);
    exp_t e;
    e.cyc   = cyc + off;
    e.dut_b = b;
    e.tag   = tag;
    e.val   = {en, sel, sen, act, bsy};
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [14:0] obs;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e   = sb.pop_front();
      obs = e.dut_b ? {b_en, b_sel, b_sen, b_act, b_bsy} : {a_en, a_sel, a_sen, a_act, a_bsy};
      check(e.tag, {17'd0, obs}, {17'd0, e.val});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    drain();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  // A select may only move on an edge where that channel's clock was already gated.
  logic [5:0] pe_a, ps_a, pe_b, ps_b;
  always @(posedge clk) begin
    pe_a = a_en; ps_a = a_sel; pe_b = b_en; ps_b = b_sel;
    #1;
    if (((a_sel ^ ps_a) & pe_a) != 6'd0) a_viol++;
    if (((b_sel ^ ps_b) & pe_b) != 6'd0) b_viol++;
  end

  initial begin
    a_rst = 1'b1; a_req = 1'b0; a_sreq = 1'b0; a_mask = 6'h00;
    b_rst = 1'b1; b_req = 1'b0; b_sreq = 1'b0; b_mask = 6'h00;
    run(3);
    expect_at(0, 1, "rst_a", 6'h3F, 6'h00, 0, 0, 0);
    expect_at(1, 1, "rst_b", 6'h3F, 6'h00, 0, 0, 0);
    run(1);
    a_rst = 1'b0; b_rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      expect_at(0, 1, "idle", 6'h3F, 6'h00, 0, 0, 0);
      step();
    end

    // Full entry; scan_en_req high must not leak through before TEST.
    a_mask = 6'h3F; a_req = 1'b1; a_sreq = 1'b1;
    expect_at(0, 1,  "en_gate",     6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 5,  "en_pre_sel",  6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 6,  "en_sel",      6'h00, 6'h3F, 0, 0, 1);
    expect_at(0, 13, "en_pre_done", 6'h00, 6'h3F, 0, 0, 1);
    expect_at(0, 14, "en_done",     6'h3F, 6'h3F, 0, 1, 0);
    run(14);

    expect_at(0, 1, "scan_1a", 6'h3F, 6'h3F, 1, 1, 0);
    run(1);
    a_sreq = 1'b0;
    expect_at(0, 1, "scan_0",  6'h3F, 6'h3F, 0, 1, 0);
    run(1);
    a_sreq = 1'b1;
    expect_at(0, 1, "scan_1b", 6'h3F, 6'h3F, 1, 1, 0);
    run(1);

    // Exit with scan_en_req still high.
    a_req = 1'b0;
    expect_at(0, 1,  "ex_gate",     6'h00, 6'h3F, 0, 0, 1);
    expect_at(0, 5,  "ex_pre_sel",  6'h00, 6'h3F, 0, 0, 1);
    expect_at(0, 6,  "ex_sel",      6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 13, "ex_pre_done", 6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 14, "ex_done",     6'h3F, 6'h00, 0, 0, 0);
    expect_at(0, 15, "func_sen",    6'h3F, 6'h00, 0, 0, 0);
    run(15);
    a_sreq = 1'b0;

    // Partial mask; a mask change mid-sequence must be ignored.
    a_mask = 6'b000101; a_req = 1'b1;
    expect_at(0, 1,  "mk_gate", 6'b111010, 6'b000000, 0, 0, 1);
    expect_at(0, 6,  "mk_sel",  6'b111010, 6'b000101, 0, 0, 1);
    expect_at(0, 14, "mk_done", 6'h3F,     6'b000101, 0, 1, 0);
    run(2);
    a_mask = 6'h3F;
    run(12);
    a_req = 1'b0;
    expect_at(0, 1,  "mk_ex_gate", 6'b111010, 6'b000101, 0, 0, 1);
    expect_at(0, 6,  "mk_ex_sel",  6'b111010, 6'b000000, 0, 0, 1);
    expect_at(0, 14, "mk_ex_done", 6'h3F,     6'b000000, 0, 0, 0);
    run(14);

    // One-cycle pulse: full entry, then full exit.
    a_mask = 6'h3F; a_req = 1'b1;
    expect_at(0, 1,  "pl_gate",     6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 14, "pl_done",     6'h3F, 6'h3F, 0, 1, 0);
    expect_at(0, 15, "pl_ex_gate",  6'h00, 6'h3F, 0, 0, 1);
    expect_at(0, 19, "pl_ex_pre",   6'h00, 6'h3F, 0, 0, 1);
    expect_at(0, 20, "pl_ex_sel",   6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 28, "pl_ex_done",  6'h3F, 6'h00, 0, 0, 0);
    run(1);
    a_req = 1'b0;
    run(27);

    // Reset while settling aborts straight to reset values.
    a_req = 1'b1;
    expect_at(0, 1, "rs_gate", 6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 6, "rs_sel",  6'h00, 6'h3F, 0, 0, 1);
    run(8);
    a_rst = 1'b1; a_req = 1'b0;
    expect_at(0, 1, "rs_mid", 6'h3F, 6'h00, 0, 0, 0);
    run(1);
    a_rst = 1'b0;
    expect_at(0, 1, "rs_post1", 6'h3F, 6'h00, 0, 0, 0);
    expect_at(0, 2, "rs_post2", 6'h3F, 6'h00, 0, 0, 0);
    run(2);
    a_req = 1'b1;
    expect_at(0, 1,  "rs_re_gate", 6'h00, 6'h00, 0, 0, 1);
    expect_at(0, 14, "rs_re_done", 6'h3F, 6'h3F, 0, 1, 0);
    run(14);

    // Minimum delays.
    b_mask = 6'h3F; b_req = 1'b1;
    expect_at(1, 1, "b_gate",    6'h00, 6'h00, 0, 0, 1);
    expect_at(1, 2, "b_pre_sel", 6'h00, 6'h00, 0, 0, 1);
    expect_at(1, 3, "b_sel",     6'h00, 6'h3F, 0, 0, 1);
    expect_at(1, 4, "b_done",    6'h3F, 6'h3F, 0, 1, 0);
    run(4);
    b_req = 1'b0;
    expect_at(1, 1, "b_ex_gate", 6'h00, 6'h3F, 0, 0, 1);
    expect_at(1, 3, "b_ex_sel",  6'h00, 6'h00, 0, 0, 1);
    expect_at(1, 4, "b_ex_done", 6'h3F, 6'h00, 0, 0, 0);
    run(4);

    check("inv_a", a_viol, 0);
    check("inv_b", b_viol, 0);
    check("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
